svga_pattern_gen: RTL and testbench

- Self-contained SVGA 800x600@60 Hz timing and test-pattern generator. Drives VGA sync and 4-bit RGB to the board connector.
- Runs from the single 100 MHz system clock. A fractional clock enable gives a 40 MHz average pixel rate.
- Also outputs a pixel-strobe mirror (pclk_mirror) so a simulation frame-capture model can sample one pixel per rising edge. Frame total is 1056 x 628 pixels.

---
 rtl/svga_pattern_gen.sv | 119 +++++++++++
 tb/tb_svga_pattern_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/svga_pattern_gen.sv
// SVGA 800x600@60 timing and colour-bar test pattern, run from the system clock through a
// fractional pixel enable. Outputs lag the raster counters by one pixel.
module svga_pattern_gen #(
    parameter int unsigned PE_NUM       = 2,
    parameter int unsigned PE_DEN       = 5,
    parameter int unsigned H_TOTAL      = 1056,
    parameter int unsigned V_TOTAL      = 628,
    parameter int unsigned H_VISIBLE    = 800,
    parameter int unsigned H_SYNC_START = 840,
    parameter int unsigned H_SYNC_END   = 967,
    parameter int unsigned V_VISIBLE    = 600,
    parameter int unsigned V_SYNC_START = 601,
    parameter int unsigned V_SYNC_END   = 604,
    parameter int unsigned BAR_WIDTH    = 100
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hs,
    output logic       vs,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       pclk_mirror
);

    localparam int unsigned AW = (PE_DEN > 1) ? $clog2(PE_DEN) : 1;
    localparam int unsigned SW = AW + 1;
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    logic [AW-1:0] acc_q, acc_d;
    logic [SW-1:0] acc_sum;
    logic          pe_q, pe_d;
    logic          pe_dly_q;
    logic [HW-1:0] hcount_q;
    logic [VW-1:0] vcount_q;
    logic [11:0]   rgb_q, rgb_next;
    logic          hs_next, vs_next;
    logic [31:0]   hc, vc, bar;
    logic          blank, border;

    // Phase accumulator: pe fires whenever the running sum crosses PE_DEN.
    always_comb begin
        acc_sum = {1'b0, acc_q} + SW'(PE_NUM);
        acc_d   = AW'(acc_sum);
        pe_d    = 1'b0;
        if (acc_sum >= SW'(PE_DEN)) begin
            acc_d = AW'(acc_sum - SW'(PE_DEN));
            pe_d  = 1'b1;
        end
    end

    always_comb begin
        hc       = 32'(hcount_q);
        vc       = 32'(vcount_q);
        bar      = hc / BAR_WIDTH;
        blank    = (hc >= H_VISIBLE) || (vc >= V_VISIBLE);
        border   = (hc == 0) || (hc == H_VISIBLE - 1) || (vc == 0) || (vc == V_VISIBLE - 1);
        hs_next  = (hc >= H_SYNC_START) && (hc <= H_SYNC_END);
        vs_next  = (vc >= V_SYNC_START) && (vc <= V_SYNC_END);
        rgb_next = 12'h000;
        if (!blank) begin
            if (border) begin
                rgb_next = 12'hFFF;
            end else begin
                case (bar)
                    32'd0:   rgb_next = 12'hFFF;
                    32'd1:   rgb_next = 12'hFF0;
                    32'd2:   rgb_next = 12'h0FF;
                    32'd3:   rgb_next = 12'h0F0;
                    32'd4:   rgb_next = 12'hF0F;
                    32'd5:   rgb_next = 12'hF00;
                    32'd6:   rgb_next = 12'h00F;
                    default: rgb_next = 12'h000;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            pe_q        <= 1'b0;
            pe_dly_q    <= 1'b0;
            pclk_mirror <= 1'b0;
            hcount_q    <= '0;
            vcount_q    <= '0;
            hs          <= 1'b0;
            vs          <= 1'b0;
            rgb_q       <= 12'h000;
        end else begin
            acc_q       <= acc_d;
            pe_q        <= pe_d;
            // Strobe rises one clk after the outputs settle.
            pe_dly_q    <= pe_q;
            pclk_mirror <= pe_dly_q;
            if (pe_q) begin
                hs    <= hs_next;
                vs    <= vs_next;
                rgb_q <= rgb_next;
                if (hcount_q == HW'(H_TOTAL - 1)) begin
                    hcount_q <= '0;
                    if (vcount_q == VW'(V_TOTAL - 1)) begin
                        vcount_q <= '0;
                    end else begin
                        vcount_q <= vcount_q + 1'b1;
                    end
                end else begin
                    hcount_q <= hcount_q + 1'b1;
                end
            end
        end
    end

    assign r = rgb_q[11:8];
    assign g = rgb_q[7:4];
    assign b = rgb_q[3:0];

endmodule

// File: tb/tb_svga_pattern_gen.sv
// Bench for svga_pattern_gen: a full-size instance and a shrunken-geometry instance, both
// checked every clock against a closed-form raster model driven by the cycle count.
module tb_svga_pattern_gen;

    localparam int PE_NUM = 2;
    localparam int PE_DEN = 5;

    typedef struct {
        int ht, hv, hss, hse, vt, vv, vss, vse, bw;
    } geom_t;

    localparam geom_t GA = '{ht: 1056, hv: 800, hss: 840, hse: 967,
                             vt: 628, vv: 600, vss: 601, vse: 604, bw: 100};
    localparam geom_t GB = '{ht: 106, hv: 80, hss: 84, hse: 96,
                             vt: 28, vv: 20, vss: 21, vse: 24, bw: 10};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs_a, vs_a, mir_a, hs_b, vs_b, mir_b;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    svga_pattern_gen dut_a (
        .clk(clk), .rst(rst), .hs(hs_a), .vs(vs_a),
        .r(r_a), .g(g_a), .b(b_a), .pclk_mirror(mir_a)
    );

    svga_pattern_gen #(
        .H_TOTAL(GB.ht), .V_TOTAL(GB.vt), .H_VISIBLE(GB.hv),
        .H_SYNC_START(GB.hss), .H_SYNC_END(GB.hse), .V_VISIBLE(GB.vv),
        .V_SYNC_START(GB.vss), .V_SYNC_END(GB.vse), .BAR_WIDTH(GB.bw)
    ) dut_b (
        .clk(clk), .rst(rst), .hs(hs_b), .vs(vs_b),
        .r(r_b), .g(g_b), .b(b_b), .pclk_mirror(mir_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 20) $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Pixel updates completed after m clock edges since reset release.
    function automatic int npix(input int m);
        return (m >= 1) ? (PE_NUM * (m - 1)) / PE_DEN : 0;
    endfunction

    function automatic logic [11:0] pix_rgb(input int h, input int v, input geom_t gm);
        logic [11:0] bars [8];
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        if (h >= gm.hv || v >= gm.vv) return 12'h000;
        if (h == 0 || h == gm.hv - 1 || v == 0 || v == gm.vv - 1) return 12'hFFF;
        if (h / gm.bw > 7) return 12'h000;
        return bars[h / gm.bw];
    endfunction

    // {pclk_mirror, hs, vs, rgb} expected after n edges since the last reset edge.
    function automatic logic [14:0] model_out(input int n, input geom_t gm);
        logic mir;
        int   p, q, h, v;
        mir = (n >= 2) && (npix(n - 1) > npix(n - 2));
        p   = npix(n);
        if (p == 0) return {mir, 14'b0};
        q = p - 1;
        h = q % gm.ht;
        v = (q / gm.ht) % gm.vt;
        return {mir, (h >= gm.hss && h <= gm.hse), (v >= gm.vss && v <= gm.vse),
                pix_rgb(h, v, gm)};
    endfunction

    // Per-cycle compare of both instances against the model.
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            if (rst) n = 0;
            else n++;
            @(negedge clk);
            check("cycle_full", 32'({mir_a, hs_a, vs_a, r_a, g_a, b_a}), 32'(model_out(n, GA)));
            check("cycle_small", 32'({mir_b, hs_b, vs_b, r_b, g_b, b_b}), 32'(model_out(n, GB)));
        end
    end

    logic [11:0] cap_rgb [2200];
    logic        cap_hs  [2200];

    initial begin
        int pix, rises, bad_gap, last_rise, first_seen;
        pix = 0; rises = 0; bad_gap = 0; last_rise = 0; first_seen = 0;

        repeat (10) @(negedge clk);
        check("reset_full", 32'({mir_a, hs_a, vs_a, r_a, g_a, b_a}), 32'd0);
        check("reset_small", 32'({mir_b, hs_b, vs_b, r_b, g_b, b_b}), 32'd0);
        rst = 1'b0;

        for (int cyc = 1; cyc <= 6000; cyc++) begin
            @(negedge clk);
            if (mir_a) begin
                if (cyc <= 5) first_seen = 1;
                if (cyc >= 101 && cyc <= 1100) rises++;
                if (last_rise != 0 && (cyc - last_rise) != 2 && (cyc - last_rise) != 3)
                    bad_gap++;
                last_rise = cyc;
                if (pix < 2200) begin
                    cap_rgb[pix] = {r_a, g_a, b_a};
                    cap_hs[pix]  = hs_a;
                    pix++;
                end
            end
        end
        check("first_strobe_within_5", 32'(first_seen), 32'd1);
        check("strobes_per_1000clk", 32'(rises), 32'd400);
        check("strobe_spacing_bad", 32'(bad_gap), 32'd0);
        check("captured_pixels", 32'(pix), 32'd2200);
        check("l1_p150", 32'(cap_rgb[1056 + 150]), 32'hFF0);
        check("l1_p650", 32'(cap_rgb[1056 + 650]), 32'h00F);
        check("l1_p750", 32'(cap_rgb[1056 + 750]), 32'h000);
        check("l1_p0", 32'(cap_rgb[1056]), 32'hFFF);
        check("l1_p799", 32'(cap_rgb[1056 + 799]), 32'hFFF);
        check("l0_p400", 32'(cap_rgb[400]), 32'hFFF);
        check("l0_p900", 32'(cap_rgb[900]), 32'h000);
        check("hs_p839", 32'(cap_hs[839]), 32'd0);
        check("hs_p840", 32'(cap_hs[840]), 32'd1);
        check("hs_p967", 32'(cap_hs[967]), 32'd1);
        check("hs_p968", 32'(cap_hs[968]), 32'd0);

        // Random mid-frame resets; each gap spans at least one full small-geometry frame.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(12000, 8000)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            rst = 1'b0;
        end
        repeat (3000) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
